// File: rtl/ahb_apb_bridge_p_pkg.sv
// Shared definitions for the AHB-Lite to APB bridge.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
//
// Contents: HTRANS and HRESP encodings, the bridge FSM state enum and a
// clog2 helper usable in localparam expressions.
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDATA  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_t;

    // Number of bits needed to hold values 0..value-1 (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                result = result + 1;
                v      = v >> 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ahb_apb_bridge_p_if.sv
// Bus bundle for the bridge: AHB-Lite slave side plus the NSLV-wide APB side.
// Latency: n/a (wires only).
// Backpressure: carried by hready_in/hready_out on AHB and pready on APB.
//
// Ports (slave modport = bridge view):
//   in : htrans, hwrite, hready_in, haddr, hwdata, pr_data, pready, pslverr
//   out: hready_out, hres, hr_data, psel, penable, pwrite, paddr, pwdata
// The master modport is the mirror image, used by whatever drives the bridge.
interface ahb_apb_bridge_p_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSLV   = 3
);

    // AHB side
    logic [1:0]             htrans;
    logic                   hwrite;
    logic                   hready_in;
    logic [ADDR_W-1:0]      haddr;
    logic [DATA_W-1:0]      hwdata;
    logic                   hready_out;
    logic [1:0]             hres;
    logic [DATA_W-1:0]      hr_data;

    // APB side
    logic [NSLV-1:0]        psel;
    logic                   penable;
    logic                   pwrite;
    logic [ADDR_W-1:0]      paddr;
    logic [DATA_W-1:0]      pwdata;
    logic [NSLV*DATA_W-1:0] pr_data;
    logic [NSLV-1:0]        pready;
    logic [NSLV-1:0]        pslverr;

    modport slave (
        input  htrans, hwrite, hready_in, haddr, hwdata,
        input  pr_data, pready, pslverr,
        output hready_out, hres, hr_data,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport master (
        output htrans, hwrite, hready_in, haddr, hwdata,
        output pr_data, pready, pslverr,
        input  hready_out, hres, hr_data,
        input  psel, penable, pwrite, paddr, pwdata
    );

endinterface

// File: rtl/ahb_apb_bridge_p_decode.sv
// Address decoder: maps an AHB address onto one of NSLV equal APB regions.
// Latency: combinational, zero cycles.
// Backpressure: none (pure function of the address).
//
// Ports:
//   addr_i : address to decode
//   hit_o  : address falls inside BASE_ADDR .. BASE_ADDR + NSLV<<SLV_SIZE_LOG2 - 1
//   idx_o  : slave index, valid only when hit_o is set
module apb_addr_decode
    import ahb_apb_pkg::*;
#(
    parameter int                ADDR_W        = 32,
    parameter int                NSLV          = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR     = 32'h8000_0000,
    parameter int                SLV_SIZE_LOG2 = 26,
    localparam int               IDX_W         = (NSLV > 1) ? clog2(NSLV) : 1
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              hit_o,
    output logic [IDX_W-1:0]  idx_o
);

    // One extra bit so the total span cannot wrap when it equals 2**ADDR_W.
    localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(NSLV) << SLV_SIZE_LOG2;

    logic [ADDR_W-1:0] offset;

    // Addresses below BASE_ADDR wrap to a huge offset and therefore miss.
    assign offset = addr_i - BASE_ADDR;
    assign hit_o  = ({1'b0, offset} < SPAN);
    assign idx_o  = IDX_W'(offset >> SLV_SIZE_LOG2);

endmodule

// File: rtl/ahb_apb_bridge_p.sv
// AHB-Lite slave that forwards each transfer to one of NSLV APB slaves.
// Latency: read 2 wait states, write 3, plus one per pready-low ACCESS cycle.
// Backpressure: hready_out low while an APB cycle or ERROR is in flight.
//
// Ports:
//   hclk, hreset : clock, synchronous active-high reset
//   bus (slave)  : AHB htrans/hwrite/hready_in/haddr/hwdata in,
//                  hready_out/hres/hr_data out; APB psel/penable/pwrite/
//                  paddr/pwdata out, pr_data/pready/pslverr in.
module ahb_apb_bridge_p
    import ahb_apb_pkg::*;
#(
    parameter int                ADDR_W        = 32,
    parameter int                DATA_W        = 32,
    parameter int                NSLV          = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR     = 32'h8000_0000,
    parameter int                SLV_SIZE_LOG2 = 26,
    parameter int                TIMEOUT       = 0
) (
    input  logic               hclk,
    input  logic               hreset,
    ahb_apb_bridge_p_if.slave  bus
);

    localparam int IDX_W = (NSLV > 1) ? clog2(NSLV) : 1;
    localparam int TO_W  = (clog2(TIMEOUT + 1) > 0) ? clog2(TIMEOUT + 1) : 1;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [TO_W-1:0]      cnt_q, cnt_d;

    // Registered outputs; their _d values are decoded from the next state.
    logic                 hready_q, hready_d;
    logic [1:0]           hres_q, hres_d;
    logic [NSLV-1:0]      psel_q, psel_d;
    logic                 penable_q, penable_d;

    logic [ADDR_W-1:0]    paddr_q;
    logic                 pwrite_q;
    logic [DATA_W-1:0]    pwdata_q;
    logic [DATA_W-1:0]    hr_data_q;

    logic                 dec_hit;
    logic [IDX_W-1:0]     dec_idx;
    logic                 accept;
    logic                 sel_ready;
    logic                 sel_err;
    logic                 timeout_hit;

    apb_addr_decode #(
        .ADDR_W        (ADDR_W),
        .NSLV          (NSLV),
        .BASE_ADDR     (BASE_ADDR),
        .SLV_SIZE_LOG2 (SLV_SIZE_LOG2)
    ) u_decode (
        .addr_i (bus.haddr),
        .hit_o  (dec_hit),
        .idx_o  (dec_idx)
    );

    // hready_q is high only in IDLE and ERR2, so acceptance is implicitly
    // limited to those two states.
    assign accept = bus.hready_in && hready_q &&
                    ((bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ));

    // Only the selected slave's handshake is looked at.
    assign sel_ready = bus.pready[idx_q];
    assign sel_err   = bus.pslverr[idx_q];

    // cnt_q counts completed pready-low ACCESS cycles, so the abort fires
    // during the TIMEOUT-th such cycle. pready high always wins.
    assign timeout_hit = (TIMEOUT != 0) && !sel_ready &&
                         ((32'(cnt_q) + 32'd1) == 32'(TIMEOUT));

    // ---------------- state register (with registered outputs) ----------
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            hready_q  <= 1'b1;
            hres_q    <= HRESP_OKAY;
            psel_q    <= '0;
            penable_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            hready_q  <= hready_d;
            hres_q    <= hres_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
        end
    end

    // ---------------- next-state logic -----------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (accept) begin
                    if (!dec_hit) begin
                        state_d = ST_ERR1;
                    end else begin
                        idx_d   = dec_idx;
                        state_d = bus.hwrite ? ST_WDATA : ST_SETUP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WDATA:  state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (sel_ready) begin
                    state_d = sel_err ? ST_ERR1 : ST_IDLE;
                end else if (timeout_hit) begin
                    state_d = ST_ERR1;
                end
            end
            ST_ERR1:   state_d = ST_ERR2;
            default:   state_d = ST_IDLE;
        endcase
    end

    // ---------------- output decode (of the next state) ------------------
    always_comb begin
        hready_d  = 1'b1;
        hres_d    = HRESP_OKAY;
        psel_d    = '0;
        penable_d = 1'b0;
        case (state_d)
            ST_WDATA: begin
                hready_d = 1'b0;
            end
            ST_SETUP: begin
                hready_d = 1'b0;
                psel_d   = NSLV'(1) << idx_d;
            end
            ST_ACCESS: begin
                hready_d  = 1'b0;
                psel_d    = NSLV'(1) << idx_d;
                penable_d = 1'b1;
            end
            ST_ERR1: begin
                hready_d = 1'b0;
                hres_d   = HRESP_ERROR;
            end
            ST_ERR2: begin
                hres_d = HRESP_ERROR;
            end
            default: begin
                hready_d = 1'b1;
            end
        endcase
    end

    // ---------------- timeout counter ------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        if (state_q != ST_ACCESS) begin
            cnt_d = '0;
        end else if (!sel_ready) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    // ---------------- datapath -------------------------------------------
    // APB address/direction only change for transfers that reach APB, so a
    // decode miss leaves the previous values on the bus.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            cnt_q     <= '0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            hr_data_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (accept && dec_hit) begin
                paddr_q  <= bus.haddr;
                pwrite_q <= bus.hwrite;
            end
            if (state_q == ST_WDATA) begin
                pwdata_q <= bus.hwdata;
            end
            if ((state_q == ST_ACCESS) && sel_ready && !sel_err && !pwrite_q) begin
                hr_data_q <= bus.pr_data[int'(idx_q)*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.hready_out = hready_q;
    assign bus.hres       = hres_q;
    assign bus.hr_data    = hr_data_q;
    assign bus.psel       = psel_q;
    assign bus.penable    = penable_q;
    assign bus.pwrite     = pwrite_q;
    assign bus.paddr      = paddr_q;
    assign bus.pwdata     = pwdata_q;

endmodule
